// File: rtl/cdc_hs_src.sv
// Source half of a four-phase req/ack crossing: captures one word, holds it on a
// registered bus, raises a level request and completes against a resynchronised ack.
module cdc_hs_src #(
  parameter int DW      = 32,
  parameter int TW      = 12,
  parameter int TIMEOUT = 4000
) (
  input  logic          clk,
  input  logic          clr_,
  input  logic          src_valid,
  output logic          src_ready,
  input  logic [DW-1:0] src_data,
  output logic          xfer_req,
  output logic [DW-1:0] xfer_data,
  input  logic          xfer_ack,
  output logic          xfer_done,
  output logic          stall_err,
  input  logic          err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

  localparam logic [TW-1:0] TO_M1 = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          a1_q, a2_q, a3_q;
  logic          req_q, req_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          ack_s, accept, stall_set;

  assign ack_s = a3_q;

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      a1_q    <= 1'b0;
      a2_q    <= 1'b0;
      a3_q    <= 1'b0;
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a1_q    <= xfer_ack;
      a2_q    <= a1_q;
      a3_q    <= a2_q;
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    src_ready = 1'b0;
    accept    = 1'b0;
    case (state_q)
      // A still-high ack means the previous handshake is draining on the far side.
      S_IDLE: begin
        src_ready = ~ack_s;
        if (src_valid && !ack_s) begin
          accept  = 1'b1;
          state_d = S_REQ;
          data_d  = src_data;
        end
      end
      S_REQ:   if (ack_s) state_d = S_REL;
      S_REL: begin
        if (!ack_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept)
      cnt_d = '0;
    else if (state_q == S_REQ && cnt_q != '1)
      cnt_d = cnt_q + TW'(1);

    // Set stays asserted for as long as the stall persists, so it beats err_clr.
    stall_set = (state_q == S_REQ) && (cnt_q >= TO_M1);
    err_d     = stall_set | (err_q & ~err_clr);
    req_d     = (state_d == S_REQ);
  end

  assign xfer_req  = req_q;
  assign xfer_data = data_q;
  assign xfer_done = done_q;
  assign stall_err = err_q;

endmodule

// File: tb/tb_cdc_hs_src.sv
// Bench for cdc_hs_src: cycle table for a single transfer, hand sequences for
// reset/stuck-ack/timeout, and a scoreboarded back-to-back and jittered-ack run.
module tb_cdc_hs_src;
  localparam int DW = 32;
  localparam int TW = 12;
  localparam int TO = 16;

  logic          clk = 1'b0, clr_ = 1'b0;
  logic          src_valid = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          man_ack = 1'b0, resp_ack = 1'b0, resp_en = 1'b0;
  logic          src_ready, xfer_req, xfer_done, stall_err, xfer_ack;
  logic [DW-1:0] xfer_data;

  assign xfer_ack = resp_en ? resp_ack : man_ack;

  cdc_hs_src #(.DW(DW), .TW(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .clr_(clr_), .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .xfer_req(xfer_req), .xfer_data(xfer_data),
    .xfer_ack(xfer_ack), .xfer_done(xfer_done), .stall_err(stall_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int n_done = 0;
  int jmax = 0;
  logic sb_en = 1'b0;
  logic [DW-1:0] q[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req_low(input string nm);
    int c = 0;
    while (xfer_req && c < 200) begin step(); c++; end
    chk(nm, xfer_req, 1'b0);
  endtask

  task automatic wait_done_pulse(input string nm);
    int c = 0;
    while (!xfer_done && c < 200) begin step(); c++; end
    chk(nm, xfer_done, 1'b1);
  endtask

  // Far-side model: follows req with a random delay, asynchronous to clk.
  initial forever begin
    #1;
    if (resp_en) begin
      if (xfer_req && !resp_ack) begin
        #($urandom_range(0, jmax));
        resp_ack = 1'b1;
      end else if (!xfer_req && resp_ack) begin
        #($urandom_range(0, jmax));
        resp_ack = 1'b0;
      end
    end
  end

  // Scoreboard: each req rise pops the next expected word; data must hold until done.
  initial begin
    logic          prev_req, busy;
    logic [DW-1:0] held, w;
    prev_req = 1'b0; busy = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (sb_en) begin
        if (xfer_req && !prev_req) begin
          if (q.size() == 0) chk("sb_extra_req", 1'b1, 1'b0);
          else begin
            w = q.pop_front();
            chk("sb_data", xfer_data, w);
          end
          busy = 1'b1;
          held = xfer_data;
        end else if (busy && xfer_data !== held) begin
          chk("sb_hold", xfer_data, held);
        end
        if (xfer_done) begin
          busy = 1'b0;
          n_done++;
        end
      end else busy = 1'b0;
      prev_req = xfer_req;
    end
  end

  // xfer_req is registered: outside reset it may only move on a rising clk edge.
  initial forever begin
    @(xfer_req);
    if (clr_) chk("req_glitch_t", DW'($time % 10), DW'(5));
  end

  typedef struct {
    logic v, ack, rdy, req, done;
  } vec_t;
  vec_t tbl[18];

  initial begin
    logic rdy;
    int   c, sent, base, idx;
    logic [DW-1:0] bw[3];

    // row i: inputs before edge Ei, expected outputs after Ei
    for (int i = 0; i < 18; i++) begin
      tbl[i].v    = (i == 0);
      tbl[i].ack  = (i >= 5 && i <= 12);
      tbl[i].req  = (i <= 7);
      tbl[i].done = (i == 16);
      tbl[i].rdy  = (i >= 16);
    end

    // reset state
    step(); step();
    chk("rst_ctl", {src_ready, xfer_req, xfer_done, stall_err}, 4'b1000);
    chk("rst_data", xfer_data, '0);
    clr_ = 1'b1;
    step();
    chk("post_rst_ctl", {src_ready, xfer_req}, 2'b10);

    // single transfer, cycle by cycle
    src_data = 32'h1234_5678;
    for (int i = 0; i < 18; i++) begin
      src_valid = tbl[i].v;
      man_ack   = tbl[i].ack;
      step();
      chk($sformatf("tbl_ctl[%0d]", i), {src_ready, xfer_req, xfer_done, stall_err},
          {tbl[i].rdy, tbl[i].req, tbl[i].done, 1'b0});
      chk($sformatf("tbl_data[%0d]", i), xfer_data, 32'h1234_5678);
    end

    // asynchronous reset in the middle of REQ
    src_valid = 1'b1; src_data = 32'hDEAD_BEEF;
    step();
    src_valid = 1'b0;
    step(); step();
    chk("mid_req", {xfer_req, xfer_data}, {1'b1, 32'hDEAD_BEEF});
    #2 clr_ = 1'b0;
    #1;
    chk("async_rst_ctl", {src_ready, xfer_req, xfer_done, stall_err}, 4'b1000);
    chk("async_rst_data", xfer_data, '0);
    step();
    clr_ = 1'b1;
    step();
    chk("rst_release", {src_ready, xfer_req}, 2'b10);

    // ack stuck high across reset release
    man_ack = 1'b1; clr_ = 1'b0;
    step(); step();
    clr_ = 1'b1;
    step(); step(); step();
    chk("stuck_rdy", src_ready, 1'b0);
    src_valid = 1'b1; src_data = 32'h55;
    step(); step();
    chk("stuck_noreq", {src_ready, xfer_req}, 2'b00);
    man_ack = 1'b0;
    step(); step();
    chk("stuck_f1", {src_ready, xfer_req}, 2'b00);
    step();
    chk("stuck_f2", {src_ready, xfer_req}, 2'b10);
    step();
    chk("stuck_f3", {xfer_req, xfer_data}, {1'b1, 32'h55});
    src_valid = 1'b0;
    man_ack = 1'b1;
    wait_req_low("stuck_rel");
    man_ack = 1'b0;
    wait_done_pulse("stuck_done");

    // stall timeout, set-wins, then clear after completion
    src_valid = 1'b1; src_data = 32'h7;
    step();
    src_valid = 1'b0;
    for (int i = 1; i < TO; i++) step();
    chk("to_pre", stall_err, 1'b0);
    step();
    chk("to_set", stall_err, 1'b1);
    for (int i = 0; i < 10; i++) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_set_wins", {stall_err, xfer_req}, 2'b11);
    man_ack = 1'b1;
    wait_req_low("to_rel");
    man_ack = 1'b0;
    wait_done_pulse("to_done");
    chk("to_sticky", stall_err, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_clr", stall_err, 1'b0);
    step();

    // back-to-back with src_valid held
    bw[0] = 32'hA; bw[1] = 32'hB; bw[2] = 32'hC;
    sb_en = 1'b1; jmax = 0; resp_en = 1'b1;
    base = n_done; idx = 0; c = 0;
    src_valid = 1'b1; src_data = bw[0];
    while (idx < 3 && c < 300) begin
      rdy = src_ready;
      step(); c++;
      if (rdy) begin
        q.push_back(bw[idx]);
        idx++;
        if (idx < 3) src_data = bw[idx];
        else src_valid = 1'b0;
      end
      if (xfer_done && idx < 3) chk("b2b_rdy_in_done", src_ready, 1'b1);
    end
    c = 0;
    while (n_done - base < 3 && c < 300) begin step(); c++; end
    chk("b2b_done_cnt", DW'(n_done - base), DW'(3));
    chk("b2b_q_empty", DW'(q.size()), '0);

    // 1000 transfers with ack edges jittered against clk
    jmax = 30; base = n_done; sent = 0; c = 0;
    while (sent < 1000 && c < 40000) begin
      if (!src_valid && $urandom_range(0, 3) != 0) begin
        src_valid = 1'b1;
        src_data = $urandom;
      end
      rdy = src_ready;
      step(); c++;
      if (src_valid && rdy) begin
        q.push_back(src_data);
        sent++;
        src_valid = 1'b0;
      end
    end
    chk("jit_sent", DW'(sent), DW'(1000));
    c = 0;
    while (n_done - base < sent && c < 500) begin step(); c++; end
    chk("jit_done_cnt", DW'(n_done - base), DW'(sent));
    chk("jit_q_empty", DW'(q.size()), '0);
    chk("jit_no_stall", stall_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
